lap_recorder: RTL

LAP_RECORDER -- requirements
Module: lap_recorder

---
 rtl/lap_recorder_pkg.sv | 15 +
 rtl/lap_ram.sv | 27 ++
 rtl/lap_recorder.sv | 118 +++++++++++
 3 files changed

// File: rtl/lap_recorder_pkg.sv
// Shared widths, entry layout and mode encoding for the lap recorder.
package lap_recorder_pkg;
  localparam int BCD_W   = 4;
  localparam int ENTRY_W = 16;

  localparam logic MODE_LIVE   = 1'b0;
  localparam logic MODE_RECALL = 1'b1;

  typedef struct packed {
    logic [BCD_W-1:0] min;
    logic [BCD_W-1:0] deka;
    logic [BCD_W-1:0] sec;
    logic [BCD_W-1:0] deci;
  } entry_t;
endpackage

// File: rtl/lap_ram.sv
// DEPTH x ENTRY_W register file: synchronous write, asynchronous read,
// every entry cleared to zero while rst_n is low.
module lap_ram
  import lap_recorder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       we_i,
  input  logic [$clog2(DEPTH)-1:0]   waddr_i,
  input  logic [ENTRY_W-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0]   raddr_i,
  output logic [ENTRY_W-1:0]         rdata_o
);
  logic [ENTRY_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/lap_recorder.sv
// Stopwatch lap store: captures the live BCD time into a ring and lets the
// user step from the newest to the oldest lap before returning to live view.
module lap_recorder
  import lap_recorder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       lap,
  input  logic                       view,
  input  logic                       clear,
  input  logic [BCD_W-1:0]           live_min,
  input  logic [BCD_W-1:0]           live_deka,
  input  logic [BCD_W-1:0]           live_sec,
  input  logic [BCD_W-1:0]           live_deci,
  output logic [BCD_W-1:0]           disp_min,
  output logic [BCD_W-1:0]           disp_deka,
  output logic [BCD_W-1:0]           disp_sec,
  output logic [BCD_W-1:0]           disp_deci,
  output logic                       recall,
  output logic [$clog2(DEPTH):0]     lap_count,
  output logic [$clog2(DEPTH)-1:0]   view_idx
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);

  logic          mode_q, mode_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW:0]   step_q, step_d;
  logic          arm_q;
  logic          we;
  logic          lap_g, view_g, clear_g;
  entry_t        live_e, rd_e, disp_e;

  // Pulses landing on the first edge after reset release are discarded.
  assign lap_g   = lap   & arm_q;
  assign view_g  = view  & arm_q;
  assign clear_g = clear & arm_q;

  assign live_e = '{min: live_min, deka: live_deka, sec: live_sec, deci: live_deci};

  always_comb begin
    mode_d   = mode_q;
    wr_ptr_d = wr_ptr_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    step_d   = step_q;
    we       = 1'b0;
    if (clear_g) begin
      mode_d   = MODE_LIVE;
      wr_ptr_d = '0;
      idx_d    = '0;
      cnt_d    = '0;
      step_d   = '0;
    end else if (lap_g) begin
      if (mode_q == MODE_LIVE) begin
        we       = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      end
    end else if (view_g) begin
      if (mode_q == MODE_LIVE) begin
        if (cnt_q != '0) begin
          mode_d = MODE_RECALL;
          idx_d  = wr_ptr_q - 1'b1;
          step_d = (AW+1)'(1);
        end
      end else if (step_q == cnt_q) begin
        mode_d = MODE_LIVE;
        idx_d  = '0;
        step_d = '0;
      end else begin
        idx_d  = idx_q - 1'b1;
        step_d = step_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q   <= MODE_LIVE;
      wr_ptr_q <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      step_q   <= '0;
      arm_q    <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      wr_ptr_q <= wr_ptr_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      step_q   <= step_d;
      arm_q    <= 1'b1;
    end
  end

  lap_ram #(.DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .rst_n   (rst),
    .we_i    (we),
    .waddr_i (wr_ptr_q),
    .wdata_i (live_e),
    .raddr_i (idx_q),
    .rdata_o (rd_e)
  );

  assign disp_e    = (mode_q == MODE_RECALL) ? rd_e : live_e;
  assign disp_min  = disp_e.min;
  assign disp_deka = disp_e.deka;
  assign disp_sec  = disp_e.sec;
  assign disp_deci = disp_e.deci;
  assign recall    = mode_q;
  assign lap_count = cnt_q;
  assign view_idx  = idx_q;
endmodule
